cdce62005_spi_responder: RTL and testbench

//  SPI slave (responder) side of the CDCE62005 3-wire + LE config interface: emulates the chip's register

---
 rtl/cdce_spi_pkg.sv | 34 +++
 rtl/spi_in_sync.sv | 46 ++++
 rtl/cdce62005_spi_responder.sv | 161 ++++++++++++++++
 tb/tb_cdce62005_spi_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cdce_spi_pkg.sv
// rtl/cdce_spi_pkg.sv - shared constants, register defaults and FSM states for the CDCE62005 SPI responder
package cdce_spi_pkg;

    typedef logic [31:0] word_t;

    localparam int    NUM_RW_REGS = 7;
    localparam [3:0]  ADDR_EEPROM = 4'h7;
    localparam [3:0]  ADDR_STATUS = 4'h8;
    localparam [3:0]  ADDR_RD_CMD = 4'hE;
    localparam word_t CMD_EEPROM  = 32'h0000_001F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    // Power-up contents of the read/write registers; the low nibble of each is its own address.
    function automatic word_t reg_default(input logic [2:0] n);
        word_t value;
        case (n)
            3'd0:    value = 32'h8140_0300;
            3'd1:    value = 32'h8140_0301;
            3'd2:    value = 32'h8140_0302;
            3'd3:    value = 32'hE840_0303;
            3'd4:    value = 32'hE840_0304;
            3'd5:    value = 32'h1000_8F35;
            3'd6:    value = 32'h04BE_03E6;
            default: value = 32'h0000_0000;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - synchronizes SCLK/LE/MOSI into clk and produces single-cycle edge pulses
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_in,
    input  logic le_in,
    input  logic mosi_in,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic le_rise,
    output logic le_fall,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] le_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   le_prev;

    // LE resets low so a reset taken mid-frame does not see a fresh LE fall and re-enter the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            le_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            le_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            le_sync   <= {le_sync[SYNC_STAGES-2:0], le_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            le_prev   <= le_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
    assign le_rise   = le_sync[SYNC_STAGES-1] & ~le_prev;
    assign le_fall   = ~le_sync[SYNC_STAGES-1] & le_prev;
    assign mosi      = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdce62005_spi_responder.sv
// rtl/cdce62005_spi_responder.sv - CDCE62005 register-file emulation behind its SPI + LE port
// Optional EEPROM shadow copy (command 0x1F) enabled by defining CDCE_SPI_RSP_EEPROM_EN.
module cdce62005_spi_responder
    import cdce_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         spi_clk_i,
    input  logic         spi_mosi_i,
    input  logic         spi_le_i,
    output logic         spi_miso_o,
    input  logic         lock_i,
    output logic [223:0] cfg_regs_o,
    output logic         wr_stb_o,
    output logic [3:0]   wr_addr_o,
    output logic         frame_err_o
);

    logic   sclk_rise;
    logic   sclk_fall;
    logic   le_rise;
    logic   le_fall;
    logic   mosi;

    state_t state;
    word_t  regs [NUM_RW_REGS];
    word_t  rx;
    word_t  tx;
    word_t  rd_word;
    logic   [5:0] bit_cnt;
    logic   rd_pend;
    logic   eeprom_flag;
    logic   frame_ok;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (spi_clk_i),
        .le_in     (spi_le_i),
        .mosi_in   (spi_mosi_i),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .le_rise   (le_rise),
        .le_fall   (le_fall),
        .mosi      (mosi)
    );

    assign frame_ok = (state == LATCH) && (bit_cnt == 6'(FRAME_BITS));

`ifdef CDCE_SPI_RSP_EEPROM_EN
    word_t shadow [NUM_RW_REGS];
    logic  shadow_valid;

    // Deliberately outside the reset domain so the shadow survives rst like a real EEPROM.
    always_ff @(posedge clk) begin
        if (!rst && frame_ok && (rx == CMD_EEPROM)) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                shadow[i] <= regs[i];
            end
            shadow_valid <= 1'b1;
        end
    end

    assign eeprom_flag = shadow_valid;
`else
    assign eeprom_flag = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        if (rx[7:4] < 4'(NUM_RW_REGS)) begin
            rd_word = regs[rx[6:4]];
        end else if (rx[7:4] == ADDR_EEPROM) begin
            rd_word = {27'h0, eeprom_flag, ADDR_EEPROM};
        end else if (rx[7:4] == ADDR_STATUS) begin
            rd_word = {27'h0, lock_i, ADDR_STATUS};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rx          <= '0;
            tx          <= '0;
            bit_cnt     <= '0;
            rd_pend     <= 1'b0;
            spi_miso_o  <= 1'b0;
            wr_stb_o    <= 1'b0;
            wr_addr_o   <= '0;
            frame_err_o <= 1'b0;
            for (int i = 0; i < NUM_RW_REGS; i++) begin
`ifdef CDCE_SPI_RSP_EEPROM_EN
                if (shadow_valid) begin
                    regs[i] <= shadow[i];
                end else begin
                    regs[i] <= reg_default(3'(i));
                end
`else
                regs[i] <= reg_default(3'(i));
`endif
            end
        end else begin
            wr_stb_o <= 1'b0;
            case (state)
                IDLE: begin
                    spi_miso_o <= 1'b0;
                    if (le_fall) begin
                        state      <= SHIFT;
                        rx         <= '0;
                        bit_cnt    <= '0;
                        spi_miso_o <= rd_pend & tx[0];
                    end
                end
                SHIFT: begin
                    // LE rise takes priority over a coincident SCLK rise; that bit is dropped.
                    if (le_rise) begin
                        state      <= LATCH;
                        spi_miso_o <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx <= {mosi, rx[31:1]};
                            if (bit_cnt != 6'd63) begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                        if (sclk_fall && rd_pend) begin
                            tx         <= {1'b0, tx[31:1]};
                            spi_miso_o <= tx[1];
                        end
                    end
                end
                LATCH: begin
                    state      <= IDLE;
                    spi_miso_o <= 1'b0;
                    rd_pend    <= 1'b0;
                    if (!frame_ok) begin
                        frame_err_o <= 1'b1;
                    end else if (rx[3:0] < 4'(NUM_RW_REGS)) begin
                        regs[rx[2:0]] <= rx;
                        wr_stb_o      <= 1'b1;
                        wr_addr_o     <= rx[3:0];
                    end else if (rx[3:0] == ADDR_RD_CMD) begin
                        rd_pend <= 1'b1;
                        tx      <= rd_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar n = 0; n < NUM_RW_REGS; n++) begin : g_cfg
        assign cfg_regs_o[32*n +: 32] = regs[n];
    end

endmodule

// File: tb/tb_cdce62005_spi_responder.sv
// tb/tb_cdce62005_spi_responder.sv - directed self-checking bench for cdce62005_spi_responder
module tb_cdce62005_spi_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         spi_clk_i = 1'b0;
    logic         spi_mosi_i = 1'b0;
    logic         spi_le_i = 1'b1;
    logic         spi_miso_o;
    logic         lock_i = 1'b0;
    logic [223:0] cfg_regs_o;
    logic         wr_stb_o;
    logic [3:0]   wr_addr_o;
    logic         frame_err_o;

    int           passed = 0;
    int           total = 0;
    int           stb_cnt = 0;
    int           stb_before;
    int           lat;
    logic [31:0]  rd;

    localparam logic [223:0] DEFAULTS = {32'h04BE03E6, 32'h10008F35, 32'hE8400304, 32'hE8400303,
                                         32'h81400302, 32'h81400301, 32'h81400300};

    cdce62005_spi_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi_clk_i   (spi_clk_i),
        .spi_mosi_i  (spi_mosi_i),
        .spi_le_i    (spi_le_i),
        .spi_miso_o  (spi_miso_o),
        .lock_i      (lock_i),
        .cfg_regs_o  (cfg_regs_o),
        .wr_stb_o    (wr_stb_o),
        .wr_addr_o   (wr_addr_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    // Counts every cycle wr_stb_o is high, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (wr_stb_o === 1'b1) stb_cnt <= stb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic spi_frame(input logic [31:0] w, input int nbits, input int rst_at,
                             output logic [31:0] r, output int latency);
        r = '0;
        latency = 0;
        spi_le_i = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            spi_mosi_i = w[i];
            repeat (6) @(negedge clk);
            r[i] = spi_miso_o;
            spi_clk_i = 1'b1;
            repeat (6) @(negedge clk);
            spi_clk_i = 1'b0;
        end
        repeat (6) @(negedge clk);
        spi_le_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wr_stb_o === 1'b1 && latency == 0) latency = k;
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        chk("reset_miso", 224'(spi_miso_o), 224'(0));
        chk("reset_wr_stb", 224'(wr_stb_o), 224'(0));
        chk("reset_wr_addr", 224'(wr_addr_o), 224'(0));
        chk("reset_frame_err", 224'(frame_err_o), 224'(0));
        chk("reset_regs", cfg_regs_o, DEFAULTS);

        // Plain write to reg0
        stb_before = stb_cnt;
        spi_frame(32'h81400300, 32, -1, rd, lat);
        chk("t1_stb_count", 224'(stb_cnt - stb_before), 224'(1));
        chk("t1_latency", 224'(lat), 224'(4));
        chk("t1_wr_addr", 224'(wr_addr_o), 224'(0));
        chk("t1_reg0", 224'(cfg_regs_o[31:0]), 224'(32'h81400300));

        // Write reg6, read it back
        spi_frame(32'h04BE03E6, 32, -1, rd, lat);
        chk("t2_wr_addr", 224'(wr_addr_o), 224'(6));
        stb_before = stb_cnt;
        spi_frame(32'h0000006E, 32, -1, rd, lat);
        chk("t2_rdcmd_no_stb", 224'(stb_cnt - stb_before), 224'(0));
        spi_frame(32'h0000000F, 32, -1, rd, lat);
        chk("t2_readback_reg6", 224'(rd), 224'(32'h04BE03E6));
        chk("t2_miso_idle", 224'(spi_miso_o), 224'(0));

        // Status register with lock high and low
        lock_i = 1'b1;
        spi_frame(32'h0000008E, 32, -1, rd, lat);
        lock_i = 1'b0;
        spi_frame(32'h0000000F, 32, -1, rd, lat);
        chk("t3_status_locked", 224'(rd), 224'(32'h00000018));
        spi_frame(32'h0000008E, 32, -1, rd, lat);
        spi_frame(32'h0000000F, 32, -1, rd, lat);
        chk("t3_status_unlocked", 224'(rd), 224'(32'h00000008));

        // Short frame: 31 clocks
        stb_before = stb_cnt;
        spi_frame(32'h10008F35, 31, -1, rd, lat);
        chk("t4_no_stb", 224'(stb_cnt - stb_before), 224'(0));
        chk("t4_reg5", 224'(cfg_regs_o[191:160]), 224'(32'h10008F35));
        chk("t4_frame_err", 224'(frame_err_o), 224'(1));
        spi_frame(32'h81400300, 32, -1, rd, lat);
        chk("t4_frame_err_sticky", 224'(frame_err_o), 224'(1));

        // Reset in the middle of a write to reg1
        stb_before = stb_cnt;
        spi_frame(32'hAAAAAAA1, 32, 16, rd, lat);
        chk("t5_no_stb", 224'(stb_cnt - stb_before), 224'(0));
        chk("t5_frame_err_clr", 224'(frame_err_o), 224'(0));
        chk("t5_wr_addr", 224'(wr_addr_o), 224'(0));
        chk("t5_miso", 224'(spi_miso_o), 224'(0));
        chk("t5_regs", cfg_regs_o, DEFAULTS);
        stb_before = stb_cnt;
        spi_frame(32'h55555551, 32, -1, rd, lat);
        chk("t5_next_stb", 224'(stb_cnt - stb_before), 224'(1));
        chk("t5_next_addr", 224'(wr_addr_o), 224'(1));
        chk("t5_next_reg1", 224'(cfg_regs_o[63:32]), 224'(32'h55555551));

        // EEPROM copy and reload across reset
        spi_frame(32'h12345670, 32, -1, rd, lat);
        spi_frame(32'h0000001F, 32, -1, rd, lat);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
`ifdef CDCE_SPI_RSP_EEPROM_EN
        chk("t6_reg0_reload", 224'(cfg_regs_o[31:0]), 224'(32'h12345670));
        chk("t6_reg1_reload", 224'(cfg_regs_o[63:32]), 224'(32'h55555551));
`else
        chk("t6_reg0_reload", 224'(cfg_regs_o[31:0]), 224'(32'h81400300));
        chk("t6_reg1_reload", 224'(cfg_regs_o[63:32]), 224'(32'h81400301));
`endif
        spi_frame(32'h0000007E, 32, -1, rd, lat);
        spi_frame(32'h0000000F, 32, -1, rd, lat);
`ifdef CDCE_SPI_RSP_EEPROM_EN
        chk("t6_readback7", 224'(rd), 224'(32'h00000017));
`else
        chk("t6_readback7", 224'(rd), 224'(32'h00000007));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
